// File: rtl/sum_result_collector.sv
// Collects every valid adder sum into a small FIFO drained by a ready/valid sink.
// Also keeps a saturating running total of accepted sums and a saturating drop count.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   in_valid/in_data adder result stream (no backpressure)
//   clr              synchronous flush of FIFO, total and counters
//   out_valid/out_data/out_ready  first-word fall-through sink interface
//   count/full/empty occupancy status
//   acc_total/acc_sat saturating total of accepted sums, sticky saturation flag
//   drop_cnt         saturating count of inputs rejected while full
module sum_result_collector #(
    parameter int W     = 20,
    parameter int DEPTH = 4,
    parameter int ACC_W = 32,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [W-1:0]               in_data,
    input  logic                       clr,
    output logic                       out_valid,
    output logic [W-1:0]               out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic [ACC_W-1:0]           acc_total,
    output logic                       acc_sat,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic             pop;
    logic             push;
    logic             drop;
    logic             we;
    logic [ACC_W:0]   sum;

    assign full      = (cnt_q == CW'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign out_valid = !empty;
    assign out_data  = mem_q[rd_q];
    assign count     = cnt_q;
    assign acc_total = acc_q;
    assign acc_sat   = sat_q;
    assign drop_cnt  = drop_q;

    // A pop frees the head slot this cycle, so a full FIFO can still take a push.
    assign pop  = out_valid && out_ready;
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;

    // Extra carry bit detects overflow of the running total.
    assign sum = {1'b0, acc_q} + {1'b0, ACC_W'(in_data)};

    // Storage is not reset; a flush only moves the pointers.
    assign we = rst_n && !clr && push;

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        sat_d  = sat_q;
        drop_d = drop_q;

        if (!rst_n || clr) begin
            wr_d   = '0;
            rd_d   = '0;
            cnt_d  = '0;
            acc_d  = '0;
            sat_d  = 1'b0;
            drop_d = '0;
        end else begin
            if (push) begin
                wr_d = wr_q + PW'(1);
                if (sum[ACC_W]) begin
                    acc_d = '1;
                    sat_d = 1'b1;
                end else begin
                    acc_d = sum[ACC_W-1:0];
                end
            end
            if (pop) begin
                rd_d = rd_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
            if (drop && (drop_q != '1)) begin
                drop_d = drop_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        wr_q   <= wr_d;
        rd_q   <= rd_d;
        cnt_q  <= cnt_d;
        acc_q  <= acc_d;
        sat_q  <= sat_d;
        drop_q <= drop_d;
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_sum_result_collector.sv
// Directed bench for sum_result_collector: reset, streaming, overflow,
// full push+pop, total saturation, drop-counter saturation and flush.
module tb_sum_result_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [19:0] in_data;
    logic        clr;
    logic        out_valid;
    logic [19:0] out_data;
    logic        out_ready;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic [31:0] acc_total;
    logic        acc_sat;
    logic [7:0]  drop_cnt;

    logic        s_in_valid;
    logic [19:0] s_in_data;
    logic        s_clr;
    logic        s_out_valid;
    logic [19:0] s_out_data;
    logic [2:0]  s_count;
    logic        s_full;
    logic        s_empty;
    logic [20:0] s_acc_total;
    logic        s_acc_sat;
    logic [7:0]  s_drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic        prev_hold = 1'b0;
    logic [19:0] prev_data = '0;

    always #5 clk = ~clk;

    sum_result_collector #(.W(20), .DEPTH(4), .ACC_W(32), .CNT_W(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .clr       (clr),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .acc_total (acc_total),
        .acc_sat   (acc_sat),
        .drop_cnt  (drop_cnt)
    );

    sum_result_collector #(.W(20), .DEPTH(4), .ACC_W(21), .CNT_W(8)) u_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s_in_valid),
        .in_data   (s_in_data),
        .clr       (s_clr),
        .out_valid (s_out_valid),
        .out_data  (s_out_data),
        .out_ready (1'b1),
        .count     (s_count),
        .full      (s_full),
        .empty     (s_empty),
        .acc_total (s_acc_total),
        .acc_sat   (s_acc_sat),
        .drop_cnt  (s_drop_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Invariants, sampled mid-cycle when everything is settled.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("inv_full_empty", 64'(full && empty), 64'd0);
            check("inv_count", 64'(count <= 3'd4), 64'd1);
            check("inv_valid", 64'(out_valid == !empty), 64'd1);
            if (prev_hold && out_valid)
                check("inv_stable", 64'(out_data), 64'(prev_data));
        end
        prev_hold = out_valid && !out_ready && rst_n && !clr;
        prev_data = out_data;
    end

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        in_data    = 20'd5;
        clr        = 1'b0;
        out_ready  = 1'b0;
        s_in_valid = 1'b0;
        s_in_data  = '0;
        s_clr      = 1'b0;

        // Reset hold with input active
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_valid", 64'(out_valid), 64'd0);
            check("rst_count", 64'(count), 64'd0);
            check("rst_acc", 64'(acc_total), 64'd0);
            check("rst_drop", 64'(drop_cnt), 64'd0);
        end
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);

        rst_n   = 1'b1;
        in_data = 20'd7;
        step();
        check("first_valid", 64'(out_valid), 64'd1);
        check("first_data", 64'(out_data), 64'd7);
        check("first_acc", 64'(acc_total), 64'd7);
        in_valid = 1'b0;
        clr      = 1'b1;
        step();
        clr = 1'b0;
        check("clr1_empty", 64'(empty), 64'd1);

        // Stream with no backpressure
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 20'd300;
        check("nobypass", 64'(out_valid), 64'd0);
        step();
        check("s300", 64'(out_data), 64'd300);
        check("s300_cnt", 64'(count), 64'd1);
        in_data = 20'd1023;
        step();
        check("s1023", 64'(out_data), 64'd1023);
        check("s1023_cnt", 64'(count), 64'd1);
        in_data = 20'd0;
        step();
        check("s0", 64'(out_data), 64'd0);
        check("s0_cnt", 64'(count), 64'd1);
        in_valid = 1'b0;
        step();
        check("s_empty", 64'(empty), 64'd1);
        check("s_acc", 64'(acc_total), 64'd1323);
        clr = 1'b1;
        step();
        clr = 1'b0;

        // Overflow: 6 pushes into 4 slots
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            in_data = 20'(i);
            step();
            if (i == 4) check("ov_full4", 64'(full), 64'd1);
        end
        in_valid = 1'b0;
        check("ov_drop", 64'(drop_cnt), 64'd2);
        check("ov_acc", 64'(acc_total), 64'd10);
        check("ov_count", 64'(count), 64'd4);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ov_pop%0d", i), 64'(out_data), 64'(i));
            step();
        end
        check("ov_empty", 64'(empty), 64'd1);
        check("ov_acc2", 64'(acc_total), 64'd10);
        clr = 1'b1;
        step();
        clr = 1'b0;

        // Full with simultaneous pop and push
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = 20'(i);
            step();
        end
        out_ready = 1'b1;
        in_data   = 20'd9;
        check("fp_head", 64'(out_data), 64'd1);
        step();
        in_valid = 1'b0;
        check("fp_count", 64'(count), 64'd4);
        check("fp_drop", 64'(drop_cnt), 64'd0);
        check("fp_acc", 64'(acc_total), 64'd19);
        begin
            logic [19:0] exp_q [4];
            exp_q = '{20'd2, 20'd3, 20'd4, 20'd9};
            for (int i = 0; i < 4; i++) begin
                check($sformatf("fp_pop%0d", i), 64'(out_data), 64'(exp_q[i]));
                step();
            end
        end
        check("fp_empty", 64'(empty), 64'd1);

        // Drop counter saturates at 255
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 20'd1;
        for (int i = 0; i < 4 + 260; i++) step();
        in_valid = 1'b0;
        check("drop_sat", 64'(drop_cnt), 64'd255);
        check("drop_cnt4", 64'(count), 64'd4);
        clr = 1'b1;
        step();
        clr = 1'b0;

        // Total saturation on the narrow-accumulator instance
        s_in_valid = 1'b1;
        s_in_data  = 20'hFFFFF;
        step();
        step();
        check("sat_acc2", 64'(s_acc_total), 64'd2097150);
        check("sat_flag2", 64'(s_acc_sat), 64'd0);
        step();
        s_in_valid = 1'b0;
        check("sat_acc3", 64'(s_acc_total), 64'd2097151);
        check("sat_flag3", 64'(s_acc_sat), 64'd1);
        step();
        check("sat_sticky", 64'(s_acc_sat), 64'd1);
        s_clr = 1'b1;
        step();
        s_clr = 1'b0;
        check("sat_clr", 64'(s_acc_sat), 64'd0);
        check("sat_clr_acc", 64'(s_acc_total), 64'd0);

        // Flush mid-operation
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 5; i <= 7; i++) begin
            in_data = 20'(i);
            step();
        end
        check("cm_count3", 64'(count), 64'd3);
        clr     = 1'b1;
        in_data = 20'd8;
        step();
        clr      = 1'b0;
        in_valid = 1'b0;
        check("cm_empty", 64'(empty), 64'd1);
        check("cm_count", 64'(count), 64'd0);
        check("cm_drop", 64'(drop_cnt), 64'd0);
        check("cm_acc", 64'(acc_total), 64'd0);
        out_ready = 1'b1;
        step();
        check("cm_no8", 64'(out_valid), 64'd0);

        // Reset mid-stream discards held entries
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 20'd11;
        step();
        step();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step();
        rst_n = 1'b1;
        check("rm_empty", 64'(empty), 64'd1);
        check("rm_acc", 64'(acc_total), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
